mi_vregfile_sb: RTL and testbench

//  Parametrised multi-issue vector register file for the vector issue stage.

---
 rtl/mi_vrf_pkg.sv | 20 ++
 rtl/mi_vrf_wr_merge.sv | 41 ++++
 rtl/mi_vregfile_sb.sv | 169 ++++++++++++++++
 tb/tb_mi_vregfile_sb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mi_vrf_pkg.sv
// Shared types and sizing helpers for the multi-issue vector register file.
//   vrf_state_e : INIT (zero-fill sweep) / RUN (normal operation)
//   NREG()      : number of entries for a given address width
//   NBYTE()     : number of byte lanes for a given register width
package mi_vrf_pkg;

    typedef enum logic {
        VRF_INIT = 1'b0,
        VRF_RUN  = 1'b1
    } vrf_state_e;

    function automatic int unsigned NREG(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    function automatic int unsigned NBYTE(input int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/mi_vrf_wr_merge.sv
// Combinational byte merge of all write ports into one register entry.
//   addr_i    : entry address being merged
//   old_i     : current contents of that entry
//   wb_en_i   : per-port write enable (already qualified by the caller)
//   wb_addr_i : per-port write address
//   wb_data_i : per-port write data
//   wb_strb_i : per-port byte enables
//   data_o    : entry contents after this cycle's writes
// Ports are scanned in ascending order so the highest-index port wins a byte.
module mi_vrf_wr_merge
    import mi_vrf_pkg::*;
#(
    parameter int unsigned REG_DW = 256,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned NWR    = 2
) (
    input  logic [REG_AW-1:0]           addr_i,
    input  logic [REG_DW-1:0]           old_i,
    input  logic [NWR-1:0]              wb_en_i,
    input  logic [NWR*REG_AW-1:0]       wb_addr_i,
    input  logic [NWR*REG_DW-1:0]       wb_data_i,
    input  logic [NWR*NBYTE(REG_DW)-1:0] wb_strb_i,
    output logic [REG_DW-1:0]           data_o
);

    localparam int unsigned NB = NBYTE(REG_DW);

    always_comb begin
        data_o = old_i;
        for (int p = 0; p < NWR; p++) begin
            if (wb_en_i[p] && (wb_addr_i[p*REG_AW +: REG_AW] == addr_i)) begin
                for (int b = 0; b < NB; b++) begin
                    if (wb_strb_i[p*NB + b]) begin
                        data_o[b*8 +: 8] = wb_data_i[p*REG_DW + b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mi_vregfile_sb.sv
// Multi-issue vector register file with busy scoreboard.
//   clk, rst      : clock, synchronous active-low reset
//   clr_i         : soft clear in RUN, restarts the zero-fill sweep
//   init_done_o   : high in RUN (array fully zero-filled)
//   wb_*_i        : NWR write/writeback ports (enable, addr, data, byte strobes, last)
//   al_*_i        : NWR alloc ports marking destination registers busy
//   rd_en_i/addr  : NRD read ports; rd_data_o registered with same-cycle write bypass
//   rd_busy_o     : combinational busy bit of each read address
module mi_vregfile_sb
    import mi_vrf_pkg::*;
#(
    parameter int unsigned REG_DW = 256,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned NRD    = 5,
    parameter int unsigned NWR    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    output logic                         init_done_o,
    input  logic [NWR-1:0]               wb_en_i,
    input  logic [NWR*REG_AW-1:0]        wb_addr_i,
    input  logic [NWR*REG_DW-1:0]        wb_data_i,
    input  logic [NWR*NBYTE(REG_DW)-1:0] wb_strb_i,
    input  logic [NWR-1:0]               wb_last_i,
    input  logic [NWR-1:0]               al_en_i,
    input  logic [NWR*REG_AW-1:0]        al_addr_i,
    input  logic [NRD-1:0]               rd_en_i,
    input  logic [NRD*REG_AW-1:0]        rd_addr_i,
    output logic [NRD*REG_DW-1:0]        rd_data_o,
    output logic [NRD-1:0]               rd_busy_o
);

    localparam int unsigned NR = NREG(REG_AW);

    vrf_state_e            state_q, state_d;
    logic [REG_AW-1:0]     ctr_q, ctr_d;
    logic [NR-1:0]         busy_q, busy_d;
    logic [NRD*REG_DW-1:0] rd_data_q, rd_data_d;
    logic [REG_DW-1:0]     mem_q [NR];

    logic                  run;
    logic                  wr_ok;
    logic [NWR-1:0]        wb_en_eff;
    logic [NWR-1:0]        al_en_eff;
    logic [NWR*REG_DW-1:0] wr_merged;
    logic [NRD*REG_DW-1:0] rd_merged;

    assign run       = (state_q == VRF_RUN);
    // clr_i drops same-cycle writes and allocs; INIT ignores them entirely.
    assign wr_ok     = run & ~clr_i;
    assign wb_en_eff = wr_ok ? wb_en_i : '0;
    assign al_en_eff = wr_ok ? al_en_i : '0;

    // One merge per write port: colliding ports compute the identical merged
    // entry, so the array write order between them does not matter.
    for (genvar p = 0; p < NWR; p++) begin : g_wr
        mi_vrf_wr_merge #(
            .REG_DW (REG_DW),
            .REG_AW (REG_AW),
            .NWR    (NWR)
        ) u_wr_merge (
            .addr_i    (wb_addr_i[p*REG_AW +: REG_AW]),
            .old_i     (mem_q[wb_addr_i[p*REG_AW +: REG_AW]]),
            .wb_en_i   (wb_en_eff),
            .wb_addr_i (wb_addr_i),
            .wb_data_i (wb_data_i),
            .wb_strb_i (wb_strb_i),
            .data_o    (wr_merged[p*REG_DW +: REG_DW])
        );
    end

    // Read bypass: each port sees the post-write value of its entry.
    for (genvar r = 0; r < NRD; r++) begin : g_rd
        mi_vrf_wr_merge #(
            .REG_DW (REG_DW),
            .REG_AW (REG_AW),
            .NWR    (NWR)
        ) u_rd_merge (
            .addr_i    (rd_addr_i[r*REG_AW +: REG_AW]),
            .old_i     (mem_q[rd_addr_i[r*REG_AW +: REG_AW]]),
            .wb_en_i   (wb_en_eff),
            .wb_addr_i (wb_addr_i),
            .wb_data_i (wb_data_i),
            .wb_strb_i (wb_strb_i),
            .data_o    (rd_merged[r*REG_DW +: REG_DW])
        );
    end

    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        busy_d    = busy_q;
        rd_data_d = rd_data_q;

        unique case (state_q)
            VRF_INIT: begin
                ctr_d = ctr_q + 1'b1;
                if (ctr_q == REG_AW'(NR - 1)) begin
                    state_d = VRF_RUN;
                end
            end
            VRF_RUN: begin
                if (clr_i) begin
                    state_d = VRF_INIT;
                    ctr_d   = '0;
                    busy_d  = '0;
                end else begin
                    for (int p = 0; p < NWR; p++) begin
                        if (wb_en_eff[p] && wb_last_i[p]) begin
                            busy_d[wb_addr_i[p*REG_AW +: REG_AW]] = 1'b0;
                        end
                    end
                    // Sets applied after clears: a new owner wins the same edge.
                    for (int p = 0; p < NWR; p++) begin
                        if (al_en_eff[p]) begin
                            busy_d[al_addr_i[p*REG_AW +: REG_AW]] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = VRF_INIT;
        endcase

        for (int r = 0; r < NRD; r++) begin
            if (rd_en_i[r]) begin
                rd_data_d[r*REG_DW +: REG_DW] = run ? rd_merged[r*REG_DW +: REG_DW] : '0;
            end
        end
    end

    always_comb begin
        rd_busy_o = '0;
        for (int r = 0; r < NRD; r++) begin
            rd_busy_o[r] = run & busy_q[rd_addr_i[r*REG_AW +: REG_AW]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= VRF_INIT;
            ctr_q     <= '0;
            busy_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Array has no reset so it can map onto SRAM; the sweep zero-fills it.
    always_ff @(posedge clk) begin
        if (state_q == VRF_INIT) begin
            mem_q[ctr_q] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wb_en_eff[p]) begin
                    mem_q[wb_addr_i[p*REG_AW +: REG_AW]] <= wr_merged[p*REG_DW +: REG_DW];
                end
            end
        end
    end

    assign rd_data_o   = rd_data_q;
    assign init_done_o = run;

endmodule

// File: tb/tb_mi_vregfile_sb.sv
module tb_mi_vregfile_sb;

    localparam int unsigned DW  = 64;
    localparam int unsigned AW  = 5;
    localparam int unsigned NRD = 3;
    localparam int unsigned NWR = 2;
    localparam int unsigned NR  = 32;
    localparam int unsigned NB  = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                clr = 1'b0;
    logic                init_done;
    logic [NWR-1:0]      wb_en = '0;
    logic [NWR*AW-1:0]   wb_addr = '0;
    logic [NWR*DW-1:0]   wb_data = '0;
    logic [NWR*NB-1:0]   wb_strb = '0;
    logic [NWR-1:0]      wb_last = '0;
    logic [NWR-1:0]      al_en = '0;
    logic [NWR*AW-1:0]   al_addr = '0;
    logic [NRD-1:0]      rd_en = '0;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*DW-1:0]   rd_data;
    logic [NRD-1:0]      rd_busy;

    always #5 clk = ~clk;

    mi_vregfile_sb #(
        .REG_DW (DW),
        .REG_AW (AW),
        .NRD    (NRD),
        .NWR    (NWR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr),
        .init_done_o (init_done),
        .wb_en_i     (wb_en),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_data),
        .wb_strb_i   (wb_strb),
        .wb_last_i   (wb_last),
        .al_en_i     (al_en),
        .al_addr_i   (al_addr),
        .rd_en_i     (rd_en),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_busy_o   (rd_busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: architectural state of the register file.
    bit            m_run = 1'b0;
    int            m_cnt = 0;
    logic [DW-1:0] m_mem [NR];
    logic [NR-1:0] m_busy = '0;
    logic [DW-1:0] m_rd [NRD];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [DW-1:0] nm [NR];
        logic [AW-1:0] a;
        if (!rst) begin
            m_run  = 1'b0;
            m_cnt  = 0;
            m_busy = '0;
            for (int p = 0; p < NRD; p++) m_rd[p] = '0;
        end else if (!m_run) begin
            for (int p = 0; p < NRD; p++) if (rd_en[p]) m_rd[p] = '0;
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == NR) begin
                m_run = 1'b1;
                m_cnt = 0;
            end
        end else if (clr) begin
            for (int p = 0; p < NRD; p++) if (rd_en[p]) m_rd[p] = m_mem[rd_addr[p*AW +: AW]];
            m_run  = 1'b0;
            m_cnt  = 0;
            m_busy = '0;
        end else begin
            nm = m_mem;
            for (int p = 0; p < NWR; p++) begin
                if (wb_en[p]) begin
                    a = wb_addr[p*AW +: AW];
                    for (int b = 0; b < NB; b++)
                        if (wb_strb[p*NB + b]) nm[a][b*8 +: 8] = wb_data[p*DW + b*8 +: 8];
                end
            end
            for (int p = 0; p < NWR; p++)
                if (wb_en[p] && wb_last[p]) m_busy[wb_addr[p*AW +: AW]] = 1'b0;
            for (int p = 0; p < NWR; p++)
                if (al_en[p]) m_busy[al_addr[p*AW +: AW]] = 1'b1;
            for (int p = 0; p < NRD; p++) if (rd_en[p]) m_rd[p] = nm[rd_addr[p*AW +: AW]];
            m_mem = nm;
        end
    endtask

    task automatic check_all();
        check("init_done", 64'(init_done), 64'(m_run));
        for (int p = 0; p < NRD; p++) begin
            check($sformatf("rd_data[%0d]", p), rd_data[p*DW +: DW], m_rd[p]);
            check($sformatf("rd_busy[%0d]", p), 64'(rd_busy[p]),
                  64'(m_run ? m_busy[rd_addr[p*AW +: AW]] : 1'b0));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        clr = 1'b0; wb_en = '0; wb_strb = '0; wb_last = '0; al_en = '0; rd_en = '0;
    endtask

    task automatic wb(input int p, input logic [4:0] a, input logic [63:0] d,
                      input logic [7:0] s, input logic l);
        wb_en[p] = 1'b1; wb_addr[p*AW +: AW] = a; wb_data[p*DW +: DW] = d;
        wb_strb[p*NB +: NB] = s; wb_last[p] = l;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        rd_en[p] = 1'b1; rd_addr[p*AW +: AW] = a;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!init_done && n < 100) begin
            cycle();
            n++;
        end
        check(tag, 64'(n), 64'd32);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) m_mem[i] = '0;
        for (int p = 0; p < NRD; p++) m_rd[p] = '0;

        // Reset and initial sweep
        cycle();
        cycle();
        check("reset_done", 64'(init_done), 64'd0);
        check("reset_rd0", rd_data[63:0], 64'd0);
        rst = 1'b1;
        wait_done("sweep_len");
        for (int i = 0; i < 11; i++) begin
            for (int p = 0; p < NRD; p++) rd(p, 5'((3 * i + p) % 32));
            cycle();
        end
        idle();

        // Two-port partial-strobe merge with same-cycle read bypass
        wb(0, 5'd3, 64'h1111_2222_3333_4444, 8'hFF, 1'b0);
        wb(1, 5'd3, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 1'b0);
        rd(0, 5'd3);
        cycle();
        check("merge_bypass", rd_data[63:0], 64'h1111_2222_CCCC_DDDD);
        idle();
        rd(1, 5'd3);
        cycle();
        check("merge_array", rd_data[127:64], 64'h1111_2222_CCCC_DDDD);
        idle();

        // Scoreboard
        rd(0, 5'd5);
        al_en[0] = 1'b1; al_addr[4:0] = 5'd5;
        cycle();
        check("busy_alloc", 64'(rd_busy[0]), 64'd1);
        al_en = '0;
        wb(0, 5'd5, 64'h5, 8'hFF, 1'b0);
        cycle();
        check("busy_nolast", 64'(rd_busy[0]), 64'd1);
        wb(1, 5'd5, 64'h55, 8'hFF, 1'b1);
        al_en[0] = 1'b1; al_addr[4:0] = 5'd5;
        cycle();
        check("busy_set_wins", 64'(rd_busy[0]), 64'd1);
        idle();
        rd(0, 5'd5);
        wb(1, 5'd5, 64'h66, 8'hFF, 1'b1);
        cycle();
        check("busy_cleared", 64'(rd_busy[0]), 64'd0);
        idle();

        // Read hold and multi-port read of the same entry
        for (int p = 0; p < NRD; p++) rd(p, 5'd1);
        cycle();
        rd_en = '0;
        wb(0, 5'd1, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
        cycle();
        check("rd_hold", rd_data[63:0], 64'd0);
        idle();
        for (int p = 0; p < NRD; p++) rd(p, 5'd1);
        cycle();
        for (int p = 0; p < NRD; p++)
            check($sformatf("rd_same[%0d]", p), rd_data[p*DW +: DW], 64'h0123_4567_89AB_CDEF);
        idle();

        // Soft clear drops same-cycle write and busy state
        wb(0, 5'd7, 64'hDEAD, 8'hFF, 1'b0);
        al_en[1] = 1'b1; al_addr[9:5] = 5'd9;
        cycle();
        idle();
        clr = 1'b1;
        wb(0, 5'd7, 64'hBEEF, 8'hFF, 1'b0);
        cycle();
        check("clr_done_low", 64'(init_done), 64'd0);
        idle();
        wait_done("clr_sweep_len");
        rd(0, 5'd7);
        rd(1, 5'd9);
        cycle();
        check("clr_x7", rd_data[63:0], 64'd0);
        check("clr_busy_x9", 64'(rd_busy[1]), 64'd0);
        idle();

        // Reset in mid-sweep restarts it
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        wait_done("rst_mid_sweep_len");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            wb_en   = 2'($urandom);
            wb_last = 2'($urandom);
            al_en   = 2'($urandom & $urandom);
            rd_en   = 3'($urandom);
            wb_strb = 16'($urandom);
            wb_data = {$urandom, $urandom, $urandom, $urandom};
            for (int p = 0; p < NWR; p++) begin
                wb_addr[p*AW +: AW] = 5'($urandom_range(0, 7));
                al_addr[p*AW +: AW] = 5'($urandom_range(0, 7));
            end
            for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = 5'($urandom_range(0, 7));
            clr = ($urandom_range(0, 79) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
